// File: rtl/usb_ls_tx.sv
// Low-speed USB transmitter: SYNC, LSB-first serialisation, bit stuffing, NRZI and EOP onto J/K/SE0.
// Define USB_TX_SYNC_EN to generate SYNC internally; otherwise the caller sends 0x80 as the first byte.
package types;
   typedef enum logic [1:0] {
      D_SE0 = 2'b00,
      D_K   = 2'b01,
      D_J   = 2'b10,
      D_SE1 = 2'b11
   } d_port_t;
endpackage

module usb_ls_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [7:0]     tx_data,
   input  logic           tx_valid,
   output logic           tx_ready,
   output types::d_port_t d,
   output logic           oe,
   output logic           busy
);
   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
`ifdef USB_TX_SYNC_EN
   localparam logic [2:0] S_SYNC    = 3'd1;
`endif
   localparam logic [2:0] S_DATA    = 3'd2;
   localparam logic [2:0] S_EOP_SE0 = 3'd3;
   localparam logic [2:0] S_EOP_J   = 3'd4;

   logic [2:0]     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     idx_q, idx_d;
   logic [7:0]     shift_q, shift_d;
   logic [2:0]     ones_q, ones_d;
   logic           stuff_q, stuff_d;
   logic           last_q, last_d;
   types::d_port_t d_q, d_d;
   logic           rdy_q, rdy_d;
   logic           act_q, act_d;

   logic           xfer, bit_end, new_bit, nxt_bit;
   logic [2:0]     ones_n;

   assign xfer    = tx_valid && rdy_q;
   assign bit_end = (cnt_q == LAST_CLK);

   function automatic types::d_port_t nrzi(input types::d_port_t cur, input logic b);
      if (b) return cur;
      return (cur == types::D_J) ? types::D_K : types::D_J;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      ones_d  = ones_q;
      stuff_d = stuff_q;
      last_d  = last_q;
      d_d     = d_q;
      new_bit = 1'b0;
      nxt_bit = 1'b0;
      ones_n  = '0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (xfer) begin
               shift_d = tx_data;
               idx_d   = '0;
               ones_d  = '0;
               stuff_d = 1'b0;
               last_d  = 1'b0;
               new_bit = 1'b1;
`ifdef USB_TX_SYNC_EN
               state_d = S_SYNC;
               nxt_bit = 1'b0;
`else
               state_d = S_DATA;
               nxt_bit = tx_data[0];
`endif
            end
         end
`ifdef USB_TX_SYNC_EN
         S_SYNC: if (bit_end) begin
            new_bit = 1'b1;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
               state_d = S_DATA;
               ones_d  = 3'd1;
               nxt_bit = shift_q[0];
            end else begin
               nxt_bit = (idx_q == 3'd6);
            end
         end
`endif
         S_DATA: if (bit_end) begin
            // stuffed bits are zeros, so they clear the run just like data zeros
            ones_n = (stuff_q || !shift_q[0]) ? 3'd0 : ones_q + 3'd1;
            ones_d = ones_n;
            if (!stuff_q) begin
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  if (xfer) shift_d = tx_data;
                  else      last_d  = 1'b1;
               end
            end
            if (ones_n == 3'd6) begin
               stuff_d = 1'b1;
               new_bit = 1'b1;
               nxt_bit = 1'b0;
            end else if (last_d) begin
               state_d = S_EOP_SE0;
               stuff_d = 1'b0;
               idx_d   = '0;
               d_d     = types::D_SE0;
            end else begin
               stuff_d = 1'b0;
               new_bit = 1'b1;
               nxt_bit = shift_d[0];
            end
         end
         S_EOP_SE0: if (bit_end) begin
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd1) begin
               state_d = S_EOP_J;
               idx_d   = '0;
               d_d     = types::D_J;
            end
         end
         S_EOP_J: if (bit_end) begin
            state_d = S_IDLE;
            last_d  = 1'b0;
            d_d     = types::D_J;
         end
         default: state_d = S_IDLE;
      endcase
      if (new_bit) d_d = nrzi(d_q, nxt_bit);
      // ready is registered, so it is asserted for the clock that will be the last one of bit 7
      rdy_d = (state_d == S_IDLE) ||
              ((state_d == S_DATA) && !stuff_d && (idx_d == 3'd7) && (cnt_d == LAST_CLK));
      act_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         ones_q  <= '0;
         stuff_q <= 1'b0;
         last_q  <= 1'b0;
         d_q     <= types::D_J;
         rdy_q   <= 1'b0;
         act_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         ones_q  <= ones_d;
         stuff_q <= stuff_d;
         last_q  <= last_d;
         d_q     <= d_d;
         rdy_q   <= rdy_d;
         act_q   <= act_d;
      end
   end

   assign tx_ready = rdy_q;
   assign d        = d_q;
   assign oe       = act_q;
   assign busy     = act_q;
endmodule
